// File: rtl/tm_spike_decoder.sv
// Per-channel spike-rate decoder: counts spikes over a window of accepted samples and drains 8 rate beats.
// Optional TM_DECODER_LEAK_EN carries half of each closed window's count into the next window.
module tm_spike_decoder #(
    parameter int unsigned WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spike_in,
    input  logic       spike_valid,
    output logic [7:0] rate_data,
    output logic [2:0] rate_ch,
    output logic       rate_valid,
    input  logic       rate_ready,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state, state_next;
    logic [7:0]       cnt        [8];
    logic [7:0]       snap       [8];
    logic [7:0]       sample_cnt [8];
    logic [7:0]       restart    [8];
    logic [WIN_W-1:0] win;
    logic [2:0]       ptr;
    logic             win_close;
    logic             beat_acc;
    logic             load_snap;
    logic             ptr_adv;
    logic             set_overrun;

    // Counts including the current sample, saturating at 255.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            sample_cnt[i] = cnt[i];
            if (spike_valid && spike_in[i] && (cnt[i] != 8'hFF))
                sample_cnt[i] = cnt[i] + 8'd1;
`ifdef TM_DECODER_LEAK_EN
            restart[i] = sample_cnt[i] >> 1;
`else
            restart[i] = '0;
`endif
        end
    end

    assign win_close = spike_valid && (win == WIN_LAST);
    assign beat_acc  = (state == DRAIN) && rate_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_snap   = 1'b0;
        ptr_adv     = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (win_close) begin
                    load_snap  = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // A close coinciding with the last accept chains straight into the next drain.
                if (beat_acc && (ptr == 3'd7) && win_close) begin
                    load_snap = 1'b1;
                end else begin
                    ptr_adv     = beat_acc;
                    set_overrun = win_close;
                    if (beat_acc && (ptr == 3'd7))
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
            for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
        end else if (spike_valid) begin
            win <= win_close ? '0 : win + 1'b1;
            for (int unsigned i = 0; i < 8; i++)
                cnt[i] <= win_close ? restart[i] : sample_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            overrun <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) snap[i] <= '0;
        end else begin
            if (load_snap) begin
                ptr <= '0;
                for (int unsigned i = 0; i < 8; i++) snap[i] <= sample_cnt[i];
            end else if (ptr_adv) begin
                ptr <= ptr + 3'd1;
            end
            if (set_overrun) overrun <= 1'b1;
        end
    end

    assign busy       = (state == DRAIN);
    assign rate_valid = busy;
    assign rate_ch    = busy ? ptr : '0;
    assign rate_data  = busy ? snap[ptr] : '0;

endmodule

// File: tb/tb_tm_spike_decoder.sv
// Scoreboard bench for tm_spike_decoder using three instances (WINDOW = 16, 256, 4) on shared stimulus.
module tb_tm_spike_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] spike_in = '0;
    logic       spike_valid = 1'b0;
    logic       rate_ready = 1'b1;

    logic [7:0] d16, d256, d4;
    logic [2:0] c16, c256, c4;
    logic       v16, v256, v4, b16, b256, b4, o16, o256, o4;

    logic [1:0] sel = 2'd0;
    logic [7:0] obs_data;
    logic [2:0] obs_ch;
    logic       obs_valid, obs_busy, obs_overrun;

    int total = 0;
    int bad = 0;
    logic [10:0] sb[$];
    int carry [8];
    int exp_last [8];
    bit leak;

    always #5 clk = ~clk;

    tm_spike_decoder #(.WINDOW(16)) u16 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
        .rate_data(d16), .rate_ch(c16), .rate_valid(v16), .rate_ready(rate_ready),
        .busy(b16), .overrun(o16));
    tm_spike_decoder #(.WINDOW(256)) u256 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
        .rate_data(d256), .rate_ch(c256), .rate_valid(v256), .rate_ready(rate_ready),
        .busy(b256), .overrun(o256));
    tm_spike_decoder #(.WINDOW(4)) u4 (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
        .rate_data(d4), .rate_ch(c4), .rate_valid(v4), .rate_ready(rate_ready),
        .busy(b4), .overrun(o4));

    always_comb begin
        case (sel)
            2'd1:    begin obs_data = d256; obs_ch = c256; obs_valid = v256; obs_busy = b256; obs_overrun = o256; end
            2'd2:    begin obs_data = d4;   obs_ch = c4;   obs_valid = v4;   obs_busy = b4;   obs_overrun = o4;   end
            default: begin obs_data = d16;  obs_ch = c16;  obs_valid = v16;  obs_busy = b16;  obs_overrun = o16;  end
        endcase
    end

    function automatic int w_of();
        return (sel == 2'd0) ? 16 : (sel == 2'd1) ? 256 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && obs_valid && rate_ready) begin
            chk("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("beat_ch_data", 32'({obs_ch, obs_data}), 32'(sb.pop_front()));
        end
    end

    task automatic cyc(input logic v, input logic [7:0] s);
        spike_valid = v;
        spike_in    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        spike_valid = 1'b0;
        spike_in = '0;
        #2;
        chk("rst_valid", 32'(obs_valid), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_data", 32'(obs_data), 32'd0);
        chk("rst_ch", 32'(obs_ch), 32'd0);
        chk("rst_overrun", 32'(obs_overrun), 32'd0);
        sb.delete();
        for (int i = 0; i < 8; i++) carry[i] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drives one full window of pattern pat; gaps inserts rejected samples carrying the inverse pattern.
    task automatic window(input logic [7:0] pat, input bit push, input bit gaps);
        int w = w_of();
        for (int n = 0; n < w; n++) begin
            if (gaps) cyc(1'b0, ~pat);
            if (n == w - 1) begin
                for (int i = 0; i < 8; i++) begin
                    exp_last[i] = carry[i] + (pat[i] ? w : 0);
                    if (exp_last[i] > 255) exp_last[i] = 255;
                    carry[i] = leak ? (exp_last[i] >> 1) : 0;
                    if (push) sb.push_back({3'(i), 8'(exp_last[i])});
                end
            end
            cyc(1'b1, pat);
        end
        spike_valid = 1'b0;
        spike_in = '0;
    endtask

    initial begin
`ifdef TM_DECODER_LEAK_EN
        leak = 1'b1;
`else
        leak = 1'b0;
`endif
        // Basic window, WINDOW=16, with rejected samples interleaved.
        sel = 2'd0;
        do_reset();
        window(8'h01, 1'b1, 1'b1);
        chk("w16_first_valid", 32'(obs_valid), 32'd1);
        chk("w16_first_ch", 32'(obs_ch), 32'd0);
        chk("w16_first_data", 32'(obs_data), 32'd16);
        idle(10);
        chk("w16_done_valid", 32'(obs_valid), 32'd0);
        chk("w16_sb_empty", 32'(sb.size()), 32'd0);
        chk("w16_overrun", 32'(obs_overrun), 32'd0);

        // Saturation, WINDOW=256.
        sel = 2'd1;
        do_reset();
        window(8'hFF, 1'b1, 1'b0);
        chk("sat_data", 32'(obs_data), 32'd255);
        idle(10);
        chk("sat_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure hold at ptr=3.
        sel = 2'd2;
        do_reset();
        window(8'hAD, 1'b1, 1'b0);
        idle(3);
        rate_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 8'h00);
            chk("stall_ch", 32'(obs_ch), 32'd3);
            chk("stall_data", 32'(obs_data), 32'(exp_last[3]));
            chk("stall_busy", 32'(obs_busy), 32'd1);
        end
        rate_ready = 1'b1;
        idle(8);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Overrun: second window closes while the first is stuck in drain.
        do_reset();
        rate_ready = 1'b0;
        window(8'h0F, 1'b1, 1'b0);
        window(8'hF0, 1'b0, 1'b0);
        chk("ovr_set", 32'(obs_overrun), 32'd1);
        chk("ovr_hold_data", 32'(obs_data), 32'd4);
        rate_ready = 1'b1;
        idle(10);
        chk("ovr_sticky", 32'(obs_overrun), 32'd1);
        chk("ovr_done_valid", 32'(obs_valid), 32'd0);
        chk("ovr_sb_empty", 32'(sb.size()), 32'd0);

        // Close exactly on the ptr=7 accept.
        do_reset();
        window(8'h03, 1'b1, 1'b0);
        idle(4);
        window(8'h0C, 1'b1, 1'b0);
        chk("b2b_valid", 32'(obs_valid), 32'd1);
        chk("b2b_ch", 32'(obs_ch), 32'd0);
        chk("b2b_overrun", 32'(obs_overrun), 32'd0);
        idle(10);
        chk("b2b_done_valid", 32'(obs_valid), 32'd0);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Leak carry-over: 4/4 then 0/4 on ch0.
        do_reset();
        window(8'h01, 1'b1, 1'b0);
        chk("leak_first", 32'(obs_data), 32'd4);
        idle(8);
        window(8'h00, 1'b1, 1'b0);
        chk("leak_second", 32'(obs_data), leak ? 32'd2 : 32'd0);
        idle(10);
        chk("leak_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-drain abandons the remaining beats.
        do_reset();
        window(8'hFF, 1'b1, 1'b0);
        idle(2);
        do_reset();
        idle(12);
        chk("abandon_valid", 32'(obs_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tm_spike_decoder.md
TM_SPIKE_DECODER -- requirements
Module: tm_spike_decoder

Interface
REQ-001 Parameter WINDOW, default 16, number of accepted spike samples per integration window; legal range 2..256.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 spike_in  input  8  one spike bit per neuron channel 0..7.
REQ-005 spike_valid  input  1  spike_in is sampled only when high.
REQ-006 rate_data  output  8  spike count of channel rate_ch for the last completed window.
REQ-007 rate_ch  output  3  channel index of rate_data.
REQ-008 rate_valid  output  1  rate_data/rate_ch valid.
REQ-009 rate_ready  input  1  downstream accepts the beat when high with rate_valid.
REQ-010 busy  output  1  high while a snapshot is being drained.
REQ-011 overrun  output  1  sticky: a completed window was dropped.

Function
REQ-012 On each clk with spike_valid=1, every channel i with spike_in[i]=1 SHALL increment its 8-bit count cnt[i], saturating at 255 (no wrap).
REQ-013 spike_valid=0 cycles SHALL change neither cnt[] nor the window counter.
REQ-014 Window counter win SHALL count accepted samples 0..WINDOW-1; the sample accepted at win=WINDOW-1 closes the window and win wraps to 0.
REQ-015 At window close the closing sample's spikes SHALL be included; snapshot value = saturated cnt[i] including that sample.
REQ-016 At window close cnt[] SHALL restart at 0 for the next sample (subject to REQ-028).
REQ-017 FSM states: IDLE, DRAIN; reset state IDLE.
REQ-018 IDLE + window close: load snap[0..7], ptr=0, go to DRAIN next cycle.
REQ-019 DRAIN: rate_valid=1, rate_ch=ptr, rate_data=snap[ptr]; first beat appears the cycle after window close (latency 1).
REQ-020 rate_data and rate_ch SHALL remain stable while rate_valid=1 and rate_ready=0.
REQ-021 Beat accepted (rate_valid and rate_ready) SHALL advance ptr by 1; acceptance at ptr=7 returns to IDLE and deasserts rate_valid next cycle unless REQ-023 applies.
REQ-022 Window close during DRAIN (other than REQ-023 case): snapshot SHALL NOT be overwritten, that window's counts are discarded, overrun set to 1.
REQ-023 Window close in the same cycle as ptr=7 acceptance: load new snapshot, ptr=0, remain DRAIN, rate_valid stays high, no overrun.
REQ-024 busy SHALL equal (state==DRAIN); rate_valid SHALL equal busy.
REQ-025 overrun SHALL clear only on reset.

Reset
REQ-026 rst_n low SHALL immediately force: cnt[]=0, snap[]=0, win=0, ptr=0, state IDLE, rate_valid=0, rate_data=0, rate_ch=0, busy=0, overrun=0.
REQ-027 Reset asserted mid-DRAIN SHALL abandon the drain; no beat is emitted after rst_n releases until a new window closes.

Configuration
REQ-028 Macro TM_DECODER_LEAK_EN: when defined, window close SHALL set cnt[i] to snapshot[i]>>1 (leaky carry-over, matching neuron decay) instead of 0; when undefined, cnt[i] restarts at 0; snapshot/drain behaviour identical in both.

Verification
REQ-029 WINDOW=16, spike_in=8'h01 with spike_valid=1 for 16 cycles, rate_ready=1 -> 8 beats ch0..7, ch0 data=16, others 0, starting the cycle after close.
REQ-030 WINDOW=256, spike_in=8'hFF every sample -> all channels report 255 (saturation), no wrap.
REQ-031 Drain with rate_ready=0 for 10 cycles at ptr=3 -> rate_ch=3, data constant, busy=1, then resumes on ready.
REQ-032 WINDOW=4, rate_ready=0 through a second window close -> overrun=1, first snapshot still drained intact; overrun stays 1 until reset.
REQ-033 Second window closes on the exact ptr=7 accept cycle -> rate_valid continuous, next beat ch0 of new window, overrun=0.
REQ-034 TM_DECODER_LEAK_EN defined, WINDOW=4, ch0 spikes 4/4 then 0/4 -> ch0 reports 4 then 2; undefined -> 4 then 0.
